// File: rtl/burst_channel.sv
// rtl/burst_channel.sv - burst-error channel between convolutional encoder and Viterbi decoder
// Registers each 2-bit symbol and injects at most one LFSR-placed burst per window.
module burst_channel #(
  parameter int unsigned W_LOG2 = 5,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [1:0]  d_i,
  input  logic        cfg_en,
  input  logic [8:0]  cfg_thresh,
  input  logic [3:0]  cfg_len,
  input  logic [1:0]  cfg_sel,
  input  logic        clr_stats_i,
  output logic        valid_o,
  output logic [1:0]  d_o,
  output logic [1:0]  err_mask_o,
  output logic [15:0] burst_ct_o,
  output logic [15:0] flip_ct_o
);

  localparam logic [W_LOG2:0]   WIN_V   = {1'b1, {W_LOG2{1'b0}}};
  localparam logic [W_LOG2-1:0] WIN_ONE = {{(W_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARMED, BURST} state_t;

  state_t            state_q, state_d;
  logic [W_LOG2-1:0] win_q;
  logic [W_LOG2-1:0] start_q, start_d;
  logic [15:0]       lfsr_q;
  logic              lfsr_fb;
  logic [3:0]        len_q;
  logic [1:0]        sel_q;
  logic [3:0]        rem_q, rem_d;
  logic              win_start;
  logic              arm;
  logic              first;
  logic [1:0]        mask;
  logic [1:0]        pop;
  logic [16:0]       flip_sum;
  logic [W_LOG2:0]   raw_start, max_start;

  assign win_start = valid_i && (win_q == '0);
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign arm       = cfg_en && (cfg_len != 4'd0) && (cfg_sel != 2'b00)
                     && ({1'b0, lfsr_q[7:0]} < cfg_thresh);

  // Clamp keeps the whole burst inside the current window.
  assign raw_start = {1'b0, lfsr_q[15 -: W_LOG2]};
  assign max_start = WIN_V - {{(W_LOG2-3){1'b0}}, cfg_len};
  assign start_d   = (raw_start > max_start) ? max_start[W_LOG2-1:0]
                                             : raw_start[W_LOG2-1:0];

  assign pop      = {1'b0, mask[1]} + {1'b0, mask[0]};
  assign flip_sum = {1'b0, flip_ct_o} + {15'd0, pop};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    first   = 1'b0;
    mask    = 2'b00;
    case (state_q)
      IDLE: begin
        if (win_start && arm) begin
          if (start_d == '0) begin
            first   = 1'b1;
            mask    = cfg_sel;
            rem_d   = cfg_len - 4'd1;
            state_d = (cfg_len == 4'd1) ? IDLE : BURST;
          end else begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (valid_i && (win_q == start_q)) begin
          first   = 1'b1;
          mask    = sel_q;
          rem_d   = len_q - 4'd1;
          state_d = (len_q == 4'd1) ? IDLE : BURST;
        end
      end
      BURST: begin
        if (valid_i) begin
          mask  = sel_q;
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rem_q      <= 4'd0;
      win_q      <= '0;
      start_q    <= '0;
      len_q      <= 4'd0;
      sel_q      <= 2'b00;
      lfsr_q     <= SEED;
      valid_o    <= 1'b0;
      d_o        <= 2'b00;
      err_mask_o <= 2'b00;
      burst_ct_o <= 16'd0;
      flip_ct_o  <= 16'd0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      valid_o    <= valid_i;
      err_mask_o <= mask;
      if (valid_i) begin
        win_q <= win_q + WIN_ONE;
        d_o   <= d_i ^ mask;
      end
      if (win_start) begin
        lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
        start_q <= start_d;
        len_q   <= cfg_len;
        sel_q   <= cfg_sel;
      end
      if (clr_stats_i) begin
        burst_ct_o <= 16'd0;
        flip_ct_o  <= 16'd0;
      end else begin
        if (first && (burst_ct_o != 16'hFFFF)) burst_ct_o <= burst_ct_o + 16'd1;
        flip_ct_o <= flip_sum[16] ? 16'hFFFF : flip_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_burst_channel.sv
// tb/tb_burst_channel.sv - randomized self-checking bench for burst_channel
// Reference model tracks each window's burst as a position interval.
module tb_burst_channel;

  localparam int W = 5;
  localparam int WIN = 32;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [1:0]  d_i = 2'b00;
  logic        cfg_en = 1'b0;
  logic [8:0]  cfg_thresh = 9'd0;
  logic [3:0]  cfg_len = 4'd0;
  logic [1:0]  cfg_sel = 2'b00;
  logic        clr_stats_i = 1'b0;
  logic        valid_o;
  logic [1:0]  d_o;
  logic [1:0]  err_mask_o;
  logic [15:0] burst_ct_o;
  logic [15:0] flip_ct_o;

  int passed = 0;
  int total = 0;

  logic [15:0] m_lfsr;
  int          m_win;
  bit          b_arm;
  int          b_lo, b_hi;
  logic [1:0]  b_sel;
  int          m_bc, m_fc;
  logic [1:0]  m_d;
  logic        exp_valid;
  logic [1:0]  exp_d, exp_mask;
  int          exp_pos;

  burst_channel #(.W_LOG2(W), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .d_i(d_i),
    .cfg_en(cfg_en), .cfg_thresh(cfg_thresh), .cfg_len(cfg_len), .cfg_sel(cfg_sel),
    .clr_stats_i(clr_stats_i), .valid_o(valid_o), .d_o(d_o), .err_mask_o(err_mask_o),
    .burst_ct_o(burst_ct_o), .flip_ct_o(flip_ct_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_win = 0; b_arm = 0; b_lo = 0; b_hi = -1; b_sel = 2'b00;
    m_bc = 0; m_fc = 0; m_d = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b0; valid_i = 1'b0; clr_stats_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic set_cfg(input logic en, input logic [8:0] th, input logic [3:0] len, input logic [1:0] sel);
    cfg_en = en; cfg_thresh = th; cfg_len = len; cfg_sel = sel;
  endtask

  task automatic step(input logic v, input logic [1:0] d, input logic clr);
    int st;
    bit arm_now, first;
    logic [1:0] m;
    valid_i = v; d_i = d; clr_stats_i = clr;
    m = 2'b00; first = 0; exp_pos = m_win;
    if (v) begin
      if (m_win == 0) begin
        arm_now = cfg_en && (cfg_len != 0) && (cfg_sel != 0) && (int'(m_lfsr[7:0]) < int'(cfg_thresh));
        st = int'(m_lfsr >> (16 - W));
        if (st > WIN - int'(cfg_len)) st = WIN - int'(cfg_len);
        b_arm = arm_now; b_lo = st; b_hi = st + int'(cfg_len) - 1; b_sel = cfg_sel;
        m_lfsr = lfsr_next(m_lfsr);
      end
      if (b_arm && m_win >= b_lo && m_win <= b_hi) begin
        m = b_sel; first = (m_win == b_lo);
      end
      m_d = d ^ m;
      m_win = (m_win + 1) % WIN;
    end
    exp_valid = v; exp_d = m_d; exp_mask = m;
    if (clr) begin
      m_bc = 0; m_fc = 0;
    end else begin
      if (first && m_bc < 65535) m_bc++;
      m_fc += int'(m[1]) + int'(m[0]);
      if (m_fc > 65535) m_fc = 65535;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({valid_o, d_o, err_mask_o} !== 5'd0)
      $display("FAIL reset_outputs: got v=%b d=%b m=%b want 0 00 00", valid_o, d_o, err_mask_o);
    else passed++;
    total++;
    if (burst_ct_o !== 16'd0 || flip_ct_o !== 16'd0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", burst_ct_o, flip_ct_o);
    else passed++;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic run_first_scenario(input string tag);
    logic [1:0] want;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 2'b00, 1'b0);
      want = (i >= 21 && i <= 24) ? 2'b10 : 2'b00;
      total++;
      if (valid_o !== 1'b1 || d_o !== want || err_mask_o !== want)
        $display("FAIL %s pos=%0d: got v=%b d=%b m=%b want v=1 d=%b m=%b", tag, i, valid_o, d_o, err_mask_o, want, want);
      else passed++;
    end
    total++;
    if (burst_ct_o !== 16'd1 || flip_ct_o !== 16'd4)
      $display("FAIL %s_counters: got %0d/%0d want 1/4", tag, burst_ct_o, flip_ct_o);
    else passed++;
  endtask

  task automatic test_single_burst();
    do_reset();
    set_cfg(1'b1, 9'd256, 4'd4, 2'b10);
    run_first_scenario("single_burst");
  endtask

  task automatic test_no_inject();
    logic [1:0] d;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 0) set_cfg(1'b1, 9'd0, 4'd4, 2'b11);
      if (i == 128) set_cfg(1'b0, 9'd256, 4'd4, 2'b11);
      d = 2'($urandom);
      step(1'b1, d, 1'b0);
      total++;
      if (valid_o !== 1'b1 || d_o !== d || err_mask_o !== 2'b00)
        $display("FAIL no_inject i=%0d: got v=%b d=%b m=%b want v=1 d=%b m=00", i, valid_o, d_o, err_mask_o, d);
      else passed++;
    end
    total++;
    if (burst_ct_o !== 16'd0 || flip_ct_o !== 16'd0)
      $display("FAIL no_inject_counters: got %0d/%0d want 0/0", burst_ct_o, flip_ct_o);
    else passed++;
  endtask

  task automatic test_full_windows();
    int nflip, lo, hi;
    do_reset();
    set_cfg(1'b1, 9'd256, 4'd15, 2'b11);
    nflip = 0; lo = -1; hi = -1;
    for (int i = 0; i < 8 * WIN; i++) begin
      step(1'b1, 2'($urandom), 1'b0);
      total++;
      if (d_o !== exp_d || err_mask_o !== exp_mask)
        $display("FAIL full_window_sym i=%0d: got d=%b m=%b want d=%b m=%b", i, d_o, err_mask_o, exp_d, exp_mask);
      else passed++;
      if (err_mask_o !== 2'b00) begin
        nflip++;
        if (lo < 0) lo = i % WIN;
        hi = i % WIN;
      end
      if (i % WIN == WIN - 1) begin
        total++;
        if (nflip != 15 || hi - lo != 14)
          $display("FAIL full_window_shape w=%0d: got flips=%0d span=%0d..%0d want 15 contiguous", i / WIN, nflip, lo, hi);
        else passed++;
        nflip = 0; lo = -1; hi = -1;
      end
    end
    total++;
    if (burst_ct_o !== 16'd8 || flip_ct_o !== 16'd240)
      $display("FAIL full_window_counters: got %0d/%0d want 8/240", burst_ct_o, flip_ct_o);
    else passed++;
  endtask

  task automatic test_toggle_valid();
    logic [1:0] want;
    do_reset();
    set_cfg(1'b1, 9'd256, 4'd4, 2'b10);
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) begin
        step(1'b1, 2'b00, 1'b0);
        want = (exp_pos >= 21 && exp_pos <= 24) ? 2'b10 : 2'b00;
        total++;
        if (valid_o !== 1'b1 || d_o !== want || err_mask_o !== want)
          $display("FAIL toggle_valid pos=%0d: got v=%b d=%b m=%b want v=1 d=%b m=%b", exp_pos, valid_o, d_o, err_mask_o, want, want);
        else passed++;
      end else begin
        step(1'b0, 2'($urandom), 1'b0);
        total++;
        if (valid_o !== 1'b0 || err_mask_o !== 2'b00 || d_o !== exp_d)
          $display("FAIL toggle_idle i=%0d: got v=%b d=%b m=%b want v=0 d=%b m=00", i, valid_o, d_o, err_mask_o, exp_d);
        else passed++;
      end
    end
    total++;
    if (burst_ct_o !== 16'd1 || flip_ct_o !== 16'd4)
      $display("FAIL toggle_counters: got %0d/%0d want 1/4", burst_ct_o, flip_ct_o);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_cfg(1'b1, 9'd256, 4'd4, 2'b10);
    for (int i = 0; i <= 22; i++) step(1'b1, 2'b00, 1'b0);
    total++;
    if (d_o !== 2'b10 || flip_ct_o !== 16'd2)
      $display("FAIL mid_burst_pre: got d=%b flips=%0d want d=10 flips=2", d_o, flip_ct_o);
    else passed++;
    #2 rst = 1'b0; valid_i = 1'b0;
    #1;
    total++;
    if ({valid_o, d_o, err_mask_o} !== 5'd0 || burst_ct_o !== 16'd0 || flip_ct_o !== 16'd0)
      $display("FAIL async_reset: got v=%b d=%b m=%b b=%0d f=%0d want all 0", valid_o, d_o, err_mask_o, burst_ct_o, flip_ct_o);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    run_first_scenario("rerun_after_reset");
  endtask

  task automatic test_saturation();
    int guard;
    do_reset();
    set_cfg(1'b1, 9'd256, 4'd15, 2'b11);
    guard = 0;
    while (m_fc < 65535 && guard < 80000) begin
      step(1'b1, 2'($urandom), 1'b0);
      guard++;
    end
    total++;
    if (flip_ct_o !== 16'hFFFF || burst_ct_o !== 16'(m_bc))
      $display("FAIL saturate_reach: got b=%0d f=%h want b=%0d f=ffff", burst_ct_o, flip_ct_o, m_bc);
    else passed++;
    for (int i = 0; i < 2 * WIN; i++) step(1'b1, 2'($urandom), 1'b0);
    total++;
    if (flip_ct_o !== 16'hFFFF || burst_ct_o !== 16'(m_bc))
      $display("FAIL saturate_stick: got b=%0d f=%h want b=%0d f=ffff", burst_ct_o, flip_ct_o, m_bc);
    else passed++;
    guard = 0;
    do begin
      step(1'b1, 2'($urandom), 1'b0);
      guard++;
    end while (exp_mask == 2'b00 && guard < 2 * WIN);
    step(1'b1, 2'($urandom), 1'b1);
    total++;
    if (err_mask_o !== 2'b11 || burst_ct_o !== 16'd0 || flip_ct_o !== 16'd0)
      $display("FAIL clr_with_flip: got m=%b b=%0d f=%0d want m=11 b=0 f=0", err_mask_o, burst_ct_o, flip_ct_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_no_inject();
    test_full_windows();
    test_toggle_valid();
    test_reset_mid_burst();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
